// File: rtl/send_arb_pkg.sv
// Shared encodings and sizing helpers for the send-path arbiter and its
// round-robin picker.
package send_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    COMMIT = 2'd2
  } arb_state_t;

  localparam int LEN_BITS_DEFAULT = 7;
  localparam int MAXLEN = (1 << LEN_BITS_DEFAULT) - 1;

  function automatic int idx_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  function automatic int max_len(input int len_bits);
    return (1 << len_bits) - 1;
  endfunction

endpackage

// File: rtl/send_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr,
// searching cyclically. Returns one-hot, index and a valid flag.
module rr_pick
  import send_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] pick_onehot,
  output logic [IW-1:0]   pick_idx,
  output logic            pick_valid
);

  logic [IW-1:0] cand;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    pick_onehot = '0;
    pick_idx    = '0;
    pick_valid  = 1'b0;
    cand        = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (req[cand]) begin
        pick_onehot       = '0;
        pick_onehot[cand] = 1'b1;
        pick_idx          = cand;
        pick_valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/send_arbiter.sv
// Round-robin arbiter streaming whole packets from NREQ producers into the
// framing ring/length FIFO. Optional stall timeout: SEND_ARB_TIMEOUT_EN.
module send_arbiter
  import send_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int LEN_BITS = 7,
  parameter int TIMEOUT  = 4800
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*8-1:0]   req_data,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ-1:0]     req_last,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     grant,
  output logic [7:0]          send_ring_data,
  output logic                send_ring_wr_en,
  input  logic                send_ring_full,
  output logic [LEN_BITS-1:0] send_fifo_data,
  output logic                send_fifo_wr_en,
  input  logic                send_fifo_full,
  output logic                busy,
  output logic                overlen_err,
  output logic                timeout_err
);

  localparam int IW      = idx_width(NREQ);
  localparam int MAX_LEN = (LEN_BITS == LEN_BITS_DEFAULT) ? MAXLEN : max_len(LEN_BITS);

  if (NREQ < 2 || NREQ > 8 || LEN_BITS < 2 || TIMEOUT < 1) begin : g_bad_params
    $error("send_arbiter: unsupported parameter set");
  end

  arb_state_t          state;
  logic [IW-1:0]       gidx;
  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       rr_next;
  logic [LEN_BITS-1:0] len;
  logic [LEN_BITS-1:0] len_inc;
  logic                at_cap;

  logic [NREQ-1:0]     pick_oh;
  logic [IW-1:0]       pick_idx;
  logic                pick_valid;

  logic                streaming;
  logic                g_valid;
  logic                g_last;
  logic                accept;
  logic                stall_tc;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req         (req),
    .ptr         (rr_ptr),
    .pick_onehot (pick_oh),
    .pick_idx    (pick_idx),
    .pick_valid  (pick_valid)
  );

  assign streaming       = (state == STREAM);
  assign g_valid         = req_valid[gidx];
  assign g_last          = req_last[gidx];
  assign accept          = streaming && g_valid && !send_ring_full;
  assign send_ring_wr_en = accept;
  assign send_ring_data  = req_data[{gidx, 3'b000} +: 8];
  assign send_fifo_wr_en = (state == COMMIT) && !send_fifo_full;
  assign busy            = (state != IDLE);

  assign rr_next = (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
  assign len_inc = len + 1'b1;
  assign at_cap  = (len == LEN_BITS'(MAX_LEN - 1));

  always_comb begin
    req_ready = '0;
    if (streaming && !send_ring_full) req_ready[gidx] = 1'b1;
  end

`ifdef SEND_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] stall_cnt;

  // Down-counter reloads on every accepted byte and while not streaming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!streaming || accept) begin
      stall_cnt <= TW'(TIMEOUT - 1);
    end else if (stall_cnt != '0) begin
      stall_cnt <= stall_cnt - 1'b1;
    end
  end

  assign stall_tc = streaming && !accept && (stall_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else if (stall_tc) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign stall_tc    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      grant          <= '0;
      gidx           <= '0;
      len            <= '0;
      rr_ptr         <= '0;
      send_fifo_data <= '0;
      overlen_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant <= pick_oh;
            gidx  <= pick_idx;
            len   <= '0;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            len <= len_inc;
            // A full-length packet is closed even without last; the
            // remainder becomes the requester's next packet.
            if (g_last || at_cap) begin
              send_fifo_data <= len_inc;
              state          <= COMMIT;
              if (!g_last) overlen_err <= 1'b1;
            end
          end else if (stall_tc) begin
            if (len == '0) begin
              grant  <= '0;
              rr_ptr <= rr_next;
              state  <= IDLE;
            end else begin
              send_fifo_data <= len;
              state          <= COMMIT;
            end
          end
        end
        COMMIT: begin
          if (!send_fifo_full) begin
            grant  <= '0;
            rr_ptr <= rr_next;
            len    <= '0;
            state  <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_send_arbiter.sv
// Directed self-checking bench for send_arbiter (NREQ=4, LEN_BITS=7, TIMEOUT=10).
module tb_send_arbiter;

  localparam int NREQ     = 4;
  localparam int LEN_BITS = 7;
  localparam int TIMEOUT  = 10;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*8-1:0]   req_data = '0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_last = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     grant;
  logic [7:0]          send_ring_data;
  logic                send_ring_wr_en;
  logic                send_ring_full = 1'b0;
  logic [LEN_BITS-1:0] send_fifo_data;
  logic                send_fifo_wr_en;
  logic                send_fifo_full = 1'b0;
  logic                busy;
  logic                overlen_err;
  logic                timeout_err;

  int checks = 0;
  int errors = 0;

  logic [8:0]          pq [NREQ][$];
  logic [NREQ-1:0]     req_hold = '0;
  logic [NREQ-1:0]     fire_q;
  logic [NREQ-1:0]     prev_grant = '0;
  logic [7:0]          ring_q [$];
  logic [LEN_BITS-1:0] fifo_q [$];
  int                  grant_log [$];

  send_arbiter #(
    .NREQ     (NREQ),
    .LEN_BITS (LEN_BITS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req             (req),
    .req_data        (req_data),
    .req_valid       (req_valid),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .grant           (grant),
    .send_ring_data  (send_ring_data),
    .send_ring_wr_en (send_ring_wr_en),
    .send_ring_full  (send_ring_full),
    .send_fifo_data  (send_fifo_data),
    .send_fifo_wr_en (send_fifo_wr_en),
    .send_fifo_full  (send_fifo_full),
    .busy            (busy),
    .overlen_err     (overlen_err),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic drive_producers();
    logic [8:0] e;
    for (int i = 0; i < NREQ; i++) begin
      if (pq[i].size() > 0) begin
        e = pq[i][0];
        req_valid[i]         = 1'b1;
        req_data[i*8 +: 8]   = e[7:0];
        req_last[i]          = e[8];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*8 +: 8]   = 8'h00;
        req_last[i]          = 1'b0;
      end
      req[i] = (pq[i].size() > 0) || req_hold[i];
    end
  endtask

  // Producers pop a byte on each handshake seen at the clock edge.
  always @(posedge clk) begin
    fire_q = req_valid & req_ready;
    #1;
    for (int i = 0; i < NREQ; i++)
      if (fire_q[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    drive_producers();
  end

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Mid-cycle monitor: logs writes due at the next edge and checks invariants.
  always @(negedge clk) begin
    if (rst_n) begin
      if (send_ring_wr_en) ring_q.push_back(send_ring_data);
      if (send_fifo_wr_en) fifo_q.push_back(send_fifo_data);
      if (grant != '0 && grant != prev_grant) grant_log.push_back(onehot_idx(grant));
      checks++;
      if (!$onehot0(grant) || (send_ring_wr_en && send_fifo_wr_en) ||
          (send_ring_wr_en && send_ring_full) || (send_fifo_wr_en && send_fifo_full)) begin
        errors++;
        $display("FAIL invariant grant=%b ring_wr=%b ring_full=%b fifo_wr=%b fifo_full=%b (required onehot0 grant, exclusive strobes, no write while full)",
                 grant, send_ring_wr_en, send_ring_full, send_fifo_wr_en, send_fifo_full);
      end
    end
    prev_grant = grant;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    ring_q.delete();
    fifo_q.delete();
    grant_log.delete();
  endtask

  task automatic test_reset();
    drive_producers();
    tick();
    tick();
    checks++;
    if (grant !== 4'b0000 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_grant_ready got grant=%b ready=%b want 0000/0000", grant, req_ready);
    end
    checks++;
    if (send_ring_wr_en !== 1'b0 || send_fifo_wr_en !== 1'b0 || send_fifo_data !== 7'd0) begin
      errors++; $display("FAIL reset_strobes got ring_wr=%b fifo_wr=%b fifo_data=%0d want 0/0/0",
                         send_ring_wr_en, send_fifo_wr_en, send_fifo_data);
    end
    checks++;
    if (busy !== 1'b0 || overlen_err !== 1'b0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags got busy=%b overlen=%b timeout=%b want 0/0/0",
                         busy, overlen_err, timeout_err);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int n;
    clear_logs();
    pq[1].push_back({1'b0, 8'h11});
    pq[1].push_back({1'b0, 8'h22});
    pq[1].push_back({1'b1, 8'h33});
    drive_producers();
    #1;
    checks++;
    if (grant !== 4'b0000) begin
      errors++; $display("FAIL single_grant_early got %b want 0000", grant);
    end
    tick();
    checks++;
    if (grant !== 4'b0010 || busy !== 1'b1) begin
      errors++; $display("FAIL single_grant got grant=%b busy=%b want 0010/1", grant, busy);
    end
    n = 0;
    while (!send_fifo_wr_en && n < 20) begin tick(); n++; end
    checks++;
    if (send_fifo_wr_en !== 1'b1 || send_fifo_data !== 7'd3 || n != 3) begin
      errors++; $display("FAIL single_commit got wr=%b len=%0d after %0d cycles want 1/3 after 3",
                         send_fifo_wr_en, send_fifo_data, n);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || fifo_q.size() != 1) begin
      errors++; $display("FAIL single_idle got busy=%b fifo_writes=%0d want 0/1", busy, fifo_q.size());
    end
    checks++;
    if (ring_q.size() != 3 || ring_q[0] !== 8'h11 || ring_q[1] !== 8'h22 || ring_q[2] !== 8'h33) begin
      errors++; $display("FAIL single_ring got %0d bytes %p want 11 22 33", ring_q.size(), ring_q);
    end
  endtask

  task automatic test_round_robin();
    int n;
    int exp_g [6] = '{0, 1, 2, 3, 0, 1};
    logic [7:0] exp_b [6] = '{8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hA1, 8'hB1};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    clear_logs();
    pq[0].push_back({1'b1, 8'hA0}); pq[0].push_back({1'b1, 8'hA1});
    pq[1].push_back({1'b1, 8'hB0}); pq[1].push_back({1'b1, 8'hB1});
    pq[2].push_back({1'b1, 8'hC0});
    pq[3].push_back({1'b1, 8'hD0});
    drive_producers();
    n = 0;
    while (fifo_q.size() < 6 && n < 100) begin tick(); n++; end
    tick();
    checks++;
    if (fifo_q.size() != 6 || grant_log.size() != 6) begin
      errors++; $display("FAIL rr_count got fifo_writes=%0d grants=%0d want 6/6", fifo_q.size(), grant_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (grant_log[i] != exp_g[i] || fifo_q[i] !== 7'd1 || ring_q[i] !== exp_b[i]) begin
          errors++; $display("FAIL rr_slot%0d got grant=%0d len=%0d byte=%h want %0d/1/%h",
                             i, grant_log[i], fifo_q[i], ring_q[i], exp_g[i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    clear_logs();
    for (int i = 1; i <= 6; i++) pq[2].push_back({(i == 6), 8'(i)});
    drive_producers();
    n = 0;
    while (ring_q.size() < 2 && n < 20) begin tick(); n++; end
    for (int k = 0; k < 5; k++) begin
      send_ring_full = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0000 || send_ring_wr_en !== 1'b0) begin
        errors++; $display("FAIL bp_ring_full cycle %0d got ready=%b wr=%b want 0000/0", k, req_ready, send_ring_wr_en);
      end
      tick();
    end
    send_ring_full = 1'b0;
    send_fifo_full = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100 || ring_q.size() != 2) begin
      errors++; $display("FAIL bp_resume got ready=%b ring_bytes=%0d want 0100/2", req_ready, ring_q.size());
    end
    n = 0;
    while (ring_q.size() < 6 && n < 20) begin tick(); n++; end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (send_fifo_wr_en !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_fifo_full cycle %0d got fifo_wr=%b busy=%b want 0/1", k, send_fifo_wr_en, busy);
      end
      tick();
    end
    send_fifo_full = 1'b0;
    #1;
    checks++;
    if (send_fifo_wr_en !== 1'b1 || send_fifo_data !== 7'd6) begin
      errors++; $display("FAIL bp_commit got wr=%b len=%0d want 1/6", send_fifo_wr_en, send_fifo_data);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || fifo_q.size() != 1 || ring_q.size() != 6 ||
        ring_q[0] !== 8'h01 || ring_q[2] !== 8'h03 || ring_q[5] !== 8'h06) begin
      errors++; $display("FAIL bp_data got busy=%b fifo_writes=%0d ring=%p want 0/1/01..06",
                         busy, fifo_q.size(), ring_q);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_logs();
    pq[1].push_back({1'b0, 8'h41});
    pq[1].push_back({1'b0, 8'h42});
    pq[1].push_back({1'b0, 8'h43});
    pq[1].push_back({1'b1, 8'h44});
    drive_producers();
    n = 0;
    while (ring_q.size() < 2 && n < 20) begin tick(); n++; end
    rst_n = 1'b0;
    pq[1].delete();
    drive_producers();
    #1;
    checks++;
    if (grant !== 4'b0000 || req_ready !== 4'b0000 || busy !== 1'b0 ||
        send_ring_wr_en !== 1'b0 || send_fifo_wr_en !== 1'b0 || send_fifo_data !== 7'd0) begin
      errors++; $display("FAIL rstmid_outputs got grant=%b ready=%b busy=%b ring_wr=%b fifo_wr=%b len=%0d want all 0",
                         grant, req_ready, busy, send_ring_wr_en, send_fifo_wr_en, send_fifo_data);
    end
    tick();
    rst_n = 1'b1;
    tick();
    pq[0].push_back({1'b1, 8'h50});
    pq[3].push_back({1'b1, 8'h53});
    drive_producers();
    tick();
    checks++;
    if (grant !== 4'b0001) begin
      errors++; $display("FAIL rstmid_ptr got grant=%b want 0001", grant);
    end
    n = 0;
    while (fifo_q.size() < 2 && n < 40) begin tick(); n++; end
    checks++;
    if (fifo_q.size() != 2 || ring_q.size() != 4 || ring_q[2] !== 8'h50 || ring_q[3] !== 8'h53 ||
        fifo_q[0] !== 7'd1 || fifo_q[1] !== 7'd1 || overlen_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_after got fifo=%p ring=%p overlen=%b want 1,1 / 41 42 50 53 / 0",
                         fifo_q, ring_q, overlen_err);
    end
  endtask

  task automatic test_overlength();
    int n;
    int bad;
    clear_logs();
    for (int i = 0; i < 130; i++) pq[3].push_back({(i == 129), 8'(i)});
    drive_producers();
    n = 0;
    while (fifo_q.size() < 2 && n < 400) begin tick(); n++; end
    tick();
    checks++;
    if (fifo_q.size() != 2) begin
      errors++; $display("FAIL ovl_count got %0d fifo writes want 2", fifo_q.size());
    end else begin
      checks++;
      if (fifo_q[0] !== 7'd127 || fifo_q[1] !== 7'd3) begin
        errors++; $display("FAIL ovl_lens got %0d,%0d want 127,3", fifo_q[0], fifo_q[1]);
      end
    end
    checks++;
    if (overlen_err !== 1'b1) begin
      errors++; $display("FAIL ovl_err got %b want 1", overlen_err);
    end
    bad = 0;
    for (int i = 0; i < ring_q.size(); i++) if (ring_q[i] !== 8'(i)) bad++;
    checks++;
    if (ring_q.size() != 130 || bad != 0 || grant_log.size() != 2) begin
      errors++; $display("FAIL ovl_ring got %0d bytes %0d wrong %0d grants want 130/0/2",
                         ring_q.size(), bad, grant_log.size());
    end
  endtask

  task automatic test_stall();
    int n;
    clear_logs();
    for (int i = 1; i <= 4; i++) pq[2].push_back({1'b0, 8'h60 + 8'(i)});
    req_hold[2] = 1'b1;
    pq[3].push_back({1'b1, 8'h70});
    drive_producers();
    n = 0;
    while (ring_q.size() < 4 && n < 20) begin tick(); n++; end
    checks++;
    if (timeout_err !== 1'b0 || grant !== 4'b0100) begin
      errors++; $display("FAIL stall_start got timeout=%b grant=%b want 0/0100", timeout_err, grant);
    end
`ifdef SEND_ARB_TIMEOUT_EN
    for (int k = 0; k < TIMEOUT; k++) begin
      checks++;
      if (send_fifo_wr_en !== 1'b0) begin
        errors++; $display("FAIL tmo_early idle cycle %0d got fifo_wr=1 want 0", k + 1);
      end
      tick();
    end
    checks++;
    if (send_fifo_wr_en !== 1'b1 || send_fifo_data !== 7'd4 || timeout_err !== 1'b1) begin
      errors++; $display("FAIL tmo_commit got wr=%b len=%0d timeout=%b want 1/4/1",
                         send_fifo_wr_en, send_fifo_data, timeout_err);
    end
    tick();
    req_hold[2] = 1'b0;
    drive_producers();
`else
    for (int k = 0; k < 20; k++) tick();
    checks++;
    if (grant !== 4'b0100 || busy !== 1'b1 || fifo_q.size() != 0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL stall_hold got grant=%b busy=%b fifo_writes=%0d timeout=%b want 0100/1/0/0",
                         grant, busy, fifo_q.size(), timeout_err);
    end
    pq[2].push_back({1'b1, 8'h65});
    req_hold[2] = 1'b0;
    drive_producers();
`endif
    n = 0;
    while (fifo_q.size() < 2 && n < 40) begin tick(); n++; end
    checks++;
    if (fifo_q.size() != 2 || grant_log.size() != 2) begin
      errors++; $display("FAIL stall_next got fifo_writes=%0d grants=%0d want 2/2", fifo_q.size(), grant_log.size());
    end else begin
      checks++;
`ifdef SEND_ARB_TIMEOUT_EN
      if (fifo_q[0] !== 7'd4 || fifo_q[1] !== 7'd1 || grant_log[1] != 3 || ring_q[4] !== 8'h70) begin
        errors++; $display("FAIL stall_after got lens=%0d,%0d next_grant=%0d byte=%h want 4,1/3/70",
                           fifo_q[0], fifo_q[1], grant_log[1], ring_q[4]);
      end
`else
      if (fifo_q[0] !== 7'd5 || fifo_q[1] !== 7'd1 || grant_log[1] != 3 || ring_q[5] !== 8'h70) begin
        errors++; $display("FAIL stall_after got lens=%0d,%0d next_grant=%0d byte=%h want 5,1/3/70",
                           fifo_q[0], fifo_q[1], grant_log[1], ring_q[5]);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_overlength();
    test_stall();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
